// File: rtl/pe_array_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_pkg
// Purpose  : Shared types and elaboration helpers for the sequential PE array.
// Revision : 1.0 - initial release
// ============================================================================
package pe_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int num_rows(input int array_size, input int row_size);
        return array_size / row_size;
    endfunction

    function automatic int cnt_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Half-LSB of the result, giving round-half-up before the shift.
    function automatic longint unsigned round_const(input int frac_bits);
        return (frac_bits > 0) ? (64'd1 << (frac_bits - 1)) : 64'd0;
    endfunction

    function automatic bit params_ok(input int data_width, input int array_size,
                                     input int row_size, input int frac_bits);
        return (data_width > 0) && (row_size > 0) && (array_size >= row_size) &&
               ((array_size % row_size) == 0) && (frac_bits >= 0) &&
               (frac_bits < data_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_array_seq_row_mul.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_mul
// Purpose  : ROW_SIZE lanes of signed fixed-point multiply/round/shift with one
//            output register. Build option: PE_ARRAY_SAT_EN (saturate vs wrap).
// Revision : 1.0 - initial release
// ============================================================================
module pe_row_mul
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_SIZE   = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROW_SIZE*DATA_WIDTH-1:0] a,
    input  logic [ROW_SIZE*DATA_WIDTH-1:0] b,
    output logic [ROW_SIZE*DATA_WIDTH-1:0] prod
);

    localparam int c_pw = 2 * DATA_WIDTH;
    localparam logic signed [c_pw-1:0] c_round = c_pw'(round_const(FRAC_BITS));

    logic [ROW_SIZE*DATA_WIDTH-1:0] w_prod;

    for (genvar j = 0; j < ROW_SIZE; j++) begin : g_lane
        logic [DATA_WIDTH-1:0]  w_a;
        logic [DATA_WIDTH-1:0]  w_b;
        logic signed [c_pw-1:0] w_ax;
        logic signed [c_pw-1:0] w_bx;
        logic signed [c_pw-1:0] w_sum;
        logic [DATA_WIDTH-1:0]  w_res;

        assign w_a   = a[(ROW_SIZE-j)*DATA_WIDTH-1 -: DATA_WIDTH];
        assign w_b   = b[(ROW_SIZE-j)*DATA_WIDTH-1 -: DATA_WIDTH];
        assign w_ax  = {{DATA_WIDTH{w_a[DATA_WIDTH-1]}}, w_a};
        assign w_bx  = {{DATA_WIDTH{w_b[DATA_WIDTH-1]}}, w_b};
        // A full signed product never reaches the top bit, so adding the
        // rounding constant cannot overflow the double-width sum.
        assign w_sum = w_ax * w_bx + c_round;

`ifdef PE_ARRAY_SAT_EN
        localparam logic signed [c_pw-1:0] c_max =
            {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        localparam logic signed [c_pw-1:0] c_min =
            {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
        logic signed [c_pw-1:0] w_shift;

        assign w_shift = w_sum >>> FRAC_BITS;
        assign w_res   = (w_shift > c_max) ? c_max[DATA_WIDTH-1:0] :
                         (w_shift < c_min) ? c_min[DATA_WIDTH-1:0] :
                                             w_shift[DATA_WIDTH-1:0];
`else
        assign w_res   = DATA_WIDTH'(w_sum >>> FRAC_BITS);
`endif

        assign w_prod[(ROW_SIZE-j)*DATA_WIDTH-1 -: DATA_WIDTH] = w_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod <= '0;
        end else begin
            prod <= w_prod;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_array_seq.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_seq
// Purpose  : Handshaked element-wise vector multiplier, one row per cycle over
//            a shared row multiplier. Build option: PE_ARRAY_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pe_array_seq
    import pe_array_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_SIZE = 128,
    parameter int ROW_SIZE   = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] A,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] B,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] Mul
);

    localparam int c_num_rows = num_rows(ARRAY_SIZE, ROW_SIZE);
    localparam int c_cnt_w    = cnt_width(c_num_rows);
    localparam int c_row_w    = ROW_SIZE * DATA_WIDTH;
    localparam logic [c_cnt_w-1:0] c_last_row = c_cnt_w'(c_num_rows - 1);

    if (!params_ok(DATA_WIDTH, ARRAY_SIZE, ROW_SIZE, FRAC_BITS)) begin : g_param_check
        $error("pe_array_seq: invalid parameter combination");
    end

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_issue;
    logic                 w_accept;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_row_w-1:0]   r_a_row [c_num_rows];
    logic [c_row_w-1:0]   r_b_row [c_num_rows];
    logic [c_row_w-1:0]   r_mul_row [c_num_rows];
    logic [c_row_w-1:0]   w_row_a;
    logic [c_row_w-1:0]   w_row_b;
    logic [c_row_w-1:0]   w_row_prod;
    logic                 r_wb_valid;
    logic [c_cnt_w-1:0]   r_wb_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = RUN;
            RUN:     if (r_cnt == c_last_row) w_next_state = DRAIN;
            DRAIN:   w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_issue   = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            RUN:     w_issue   = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = in_ready & in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_issue && (r_cnt != c_last_row)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operands are pure datapath: only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < c_num_rows; r++) begin
                r_a_row[r] <= A[(c_num_rows-r)*c_row_w-1 -: c_row_w];
                r_b_row[r] <= B[(c_num_rows-r)*c_row_w-1 -: c_row_w];
            end
        end
    end

    assign w_row_a = r_a_row[r_cnt];
    assign w_row_b = r_b_row[r_cnt];

    pe_row_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_SIZE   (ROW_SIZE),
        .FRAC_BITS  (FRAC_BITS)
    ) u_row_mul (
        .clk  (clk),
        .rst  (rst),
        .a    (w_row_a),
        .b    (w_row_b),
        .prod (w_row_prod)
    );

    // The row tag travels alongside the multiplier's register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_row   <= '0;
            for (int r = 0; r < c_num_rows; r++) begin
                r_mul_row[r] <= '0;
            end
        end else begin
            r_wb_valid <= w_issue;
            r_wb_row   <= r_cnt;
            if (r_wb_valid) begin
                r_mul_row[r_wb_row] <= w_row_prod;
            end
        end
    end

    for (genvar r = 0; r < c_num_rows; r++) begin : g_pack
        assign Mul[(c_num_rows-r)*c_row_w-1 -: c_row_w] = r_mul_row[r];
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_array_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_array_seq
// Purpose  : Self-checking bench for pe_array_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_array_seq;

    localparam int DW = 16;
    localparam int AS = 128;
    localparam int RS = 16;
    localparam int FB = 8;
    localparam int NR = AS / RS;

    typedef logic [DW*AS-1:0] vec_t;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready;
    logic out_valid;
    vec_t A = '0;
    vec_t B = '0;
    vec_t Mul;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_array_seq #(
        .DATA_WIDTH (DW),
        .ARRAY_SIZE (AS),
        .ROW_SIZE   (RS),
        .FRAC_BITS  (FB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Mul       (Mul)
    );

    function automatic logic [DW-1:0] get_lane(input vec_t v, input int i);
        return v[(AS-i)*DW-1 -: DW];
    endfunction

    function automatic vec_t set_lane(input vec_t v, input int i, input logic [DW-1:0] x);
        vec_t t;
        t = v;
        t[(AS-i)*DW-1 -: DW] = x;
        return t;
    endfunction

    // Real-number semantics: exact product, +half LSB, floor-divide by 2^FB.
    function automatic logic [DW-1:0] ref_lane(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint p;
        longint q;
        p = longint'($signed(a)) * longint'($signed(b));
        if (FB > 0) p = p + (longint'(1) << (FB - 1));
        q = p >>> FB;
`ifdef PE_ARRAY_SAT_EN
        if (q > (longint'(1) << (DW - 1)) - 1) q = (longint'(1) << (DW - 1)) - 1;
        if (q < -(longint'(1) << (DW - 1)))    q = -(longint'(1) << (DW - 1));
`endif
        return q[DW-1:0];
    endfunction

    function automatic vec_t ref_vec(input vec_t a, input vec_t b);
        vec_t r;
        r = '0;
        for (int i = 0; i < AS; i++) r = set_lane(r, i, ref_lane(get_lane(a, i), get_lane(b, i)));
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v = '0;
        for (int i = 0; i < AS; i++) v = set_lane(v, i, DW'($urandom));
        return v;
    endfunction

    function automatic int first_diff(input vec_t x, input vec_t y);
        for (int i = 0; i < AS; i++) if (get_lane(x, i) !== get_lane(y, i)) return i;
        return 0;
    endfunction

    task automatic drive(input vec_t a, input vec_t b);
        A = a;
        B = b;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                t_acc = cyc;
                in_valid = 1'b0;
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (Mul !== '0) begin n_err++; $display("FAIL reset_mul: lane %0d got %h want 0000", first_diff(Mul, '0), get_lane(Mul, first_diff(Mul, '0))); end
    endtask

    task automatic test_single();
        vec_t a, b, e;
        bit ok;
        int lat, l;
        a = set_lane('0, 0, 16'h0100);
        b = set_lane('0, 0, 16'h0280);
        e = ref_vec(a, b);
        drive(a, b);
        wait_accept(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_accept: got timeout want accept"); end
        wait_out(lat);
        n_vec++; if (lat !== NR + 1) begin n_err++; $display("FAIL single_latency: got %0d want %0d", lat, NR + 1); end
        n_vec++; if (get_lane(Mul, 0) !== 16'h0280) begin n_err++; $display("FAIL single_lane0: got %h want 0280", get_lane(Mul, 0)); end
        n_vec++; if (Mul !== e) begin n_err++; l = first_diff(Mul, e); $display("FAIL single_vec: lane %0d got %h want %h", l, get_lane(Mul, l), get_lane(e, l)); end
        pop();
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL single_pop: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_rounding();
        vec_t a, b, e;
        bit ok;
        int lat, l;
        a = set_lane(set_lane('0, 5, 16'hFF00), 127, 16'h0001);
        b = set_lane(set_lane('0, 5, 16'h0180), 127, 16'h0080);
        e = ref_vec(a, b);
        drive(a, b);
        wait_accept(ok);
        wait_out(lat);
        n_vec++; if (!ok || lat < 0) begin n_err++; $display("FAIL round_handshake: got ok=%0d lat=%0d want 1/%0d", ok, lat, NR + 1); end
        n_vec++; if (get_lane(Mul, 5) !== 16'hFE80) begin n_err++; $display("FAIL round_lane5: got %h want fe80", get_lane(Mul, 5)); end
        n_vec++; if (get_lane(Mul, 127) !== 16'h0001) begin n_err++; $display("FAIL round_lane127: got %h want 0001", get_lane(Mul, 127)); end
        n_vec++; if (Mul !== e) begin n_err++; l = first_diff(Mul, e); $display("FAIL round_vec: lane %0d got %h want %h", l, get_lane(Mul, l), get_lane(e, l)); end
        pop();
    endtask

    task automatic test_saturation();
        vec_t a, b, e;
        bit ok;
        int lat, l;
        logic [DW-1:0] x0, x1;
`ifdef PE_ARRAY_SAT_EN
        x0 = 16'h7FFF; x1 = 16'h8000;
`else
        x0 = 16'hFE00; x1 = 16'h0000;
`endif
        a = set_lane(set_lane(rand_vec(), 0, 16'h7F00), 1, 16'h8000);
        b = set_lane(set_lane(rand_vec(), 0, 16'h0200), 1, 16'h0200);
        e = ref_vec(a, b);
        drive(a, b);
        wait_accept(ok);
        wait_out(lat);
        n_vec++; if (!ok || lat < 0) begin n_err++; $display("FAIL sat_handshake: got ok=%0d lat=%0d want 1/%0d", ok, lat, NR + 1); end
        n_vec++; if (get_lane(Mul, 0) !== x0) begin n_err++; $display("FAIL sat_lane0: got %h want %h", get_lane(Mul, 0), x0); end
        n_vec++; if (get_lane(Mul, 1) !== x1) begin n_err++; $display("FAIL sat_lane1: got %h want %h", get_lane(Mul, 1), x1); end
        n_vec++; if (Mul !== e) begin n_err++; l = first_diff(Mul, e); $display("FAIL sat_vec: lane %0d got %h want %h", l, get_lane(Mul, l), get_lane(e, l)); end
        pop();
    endtask

    task automatic test_backpressure();
        vec_t a, b, e, a2, b2, e2;
        bit ok;
        int lat, l;
        a = rand_vec(); b = rand_vec(); e = ref_vec(a, b);
        a2 = rand_vec(); b2 = rand_vec(); e2 = ref_vec(a2, b2);
        drive(a, b);
        wait_accept(ok);
        wait_out(lat);
        n_vec++; if (!ok || lat !== NR + 1) begin n_err++; $display("FAIL bp_first: got ok=%0d lat=%0d want 1/%0d", ok, lat, NR + 1); end
        drive(a2, b2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_flags: cycle %0d got out_valid=%b in_ready=%b want 1/0", k, out_valid, in_ready); end
            n_vec++; if (Mul !== e) begin n_err++; l = first_diff(Mul, e); $display("FAIL bp_hold_mul: lane %0d got %h want %h", l, get_lane(Mul, l), get_lane(e, l)); end
        end
        pop();
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        t_acc = cyc;
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_next_accept: got in_ready=%b want 0", in_ready); end
        wait_out(lat);
        n_vec++; if (lat !== NR + 1) begin n_err++; $display("FAIL bp_second_latency: got %0d want %0d", lat, NR + 1); end
        n_vec++; if (Mul !== e2) begin n_err++; l = first_diff(Mul, e2); $display("FAIL bp_second_vec: lane %0d got %h want %h", l, get_lane(Mul, l), get_lane(e2, l)); end
        pop();
    endtask

    task automatic test_mid_reset();
        vec_t a, b, e;
        bit ok;
        int lat, l;
        a = rand_vec(); b = rand_vec();
        drive(a, b);
        wait_accept(ok);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_flags: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        n_vec++; if (Mul !== '0) begin n_err++; l = first_diff(Mul, '0); $display("FAIL midrst_mul: lane %0d got %h want 0000", l, get_lane(Mul, l)); end
        a = rand_vec(); b = rand_vec(); e = ref_vec(a, b);
        drive(a, b);
        wait_accept(ok);
        wait_out(lat);
        n_vec++; if (!ok || lat !== NR + 1) begin n_err++; $display("FAIL midrst_fresh_timing: got ok=%0d lat=%0d want 1/%0d", ok, lat, NR + 1); end
        n_vec++; if (Mul !== e) begin n_err++; l = first_diff(Mul, e); $display("FAIL midrst_fresh_vec: lane %0d got %h want %h", l, get_lane(Mul, l), get_lane(e, l)); end
        pop();
    endtask

    task automatic test_back_to_back();
        vec_t a, b, e;
        bit ok;
        int lat, l, t_prev;
        t_prev = 0;
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            a = rand_vec(); b = rand_vec(); e = ref_vec(a, b);
            drive(a, b);
            wait_accept(ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_accept: vector %0d got timeout want accept", v); end
            if (v > 0) begin
                n_vec++; if (t_acc - t_prev !== NR + 3) begin n_err++; $display("FAIL b2b_spacing: vector %0d got %0d want %0d", v, t_acc - t_prev, NR + 3); end
            end
            t_prev = t_acc;
            wait_out(lat);
            n_vec++; if (Mul !== e || lat < 0) begin n_err++; l = first_diff(Mul, e); $display("FAIL b2b_vec: vector %0d lat %0d lane %0d got %h want %h", v, lat, l, get_lane(Mul, l), get_lane(e, l)); end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
